// File: rtl/logo_bounce_engine.sv
// logo_bounce_engine
// ------------------
// Animation stage that sits in front of the logo LUT. It keeps a logo position
// that moves once per frame and bounces off the screen edges. It also turns the
// raster counters into logo-relative LUT coordinates, and keeps an RGB mask
// that steps on every wall hit.
//
// Ports
//   clk_i           pixel clock
//   rst_ni          asynchronous active-low reset
//   vsync_i         vertical sync (polarity set by VSYNC_ACTIVE_LOW)
//   active_video_i  horizontal AND vertical active video
//   x_i / y_i       raster pixel / line counters
//   lut_x_o/lut_y_o registered logo-relative coordinates, 0 outside the window
//   in_window_o     registered: pixel inside the logo and video active
//   color_o         RGB mask {r,g,b}, never 3'b000
//   pos_x_o/pos_y_o current logo left / top edge
//   corner_hit_o    (LOGO_BOUNCE_CORNER_CNT_EN only) 1-cycle pulse after a corner hit
//   corner_cnt_o    (LOGO_BOUNCE_CORNER_CNT_EN only) saturating corner-hit count
//
// Optional build macro: LOGO_BOUNCE_CORNER_CNT_EN adds the corner hit pulse and
// the corner hit counter.
//
// Timing: the window outputs have one cycle of latency. The position and colour
// change only on the frame tick. The tick falls in vertical blanking, so the
// logo never moves in the middle of a visible frame.

module logo_bounce_engine #(
  parameter int H_ACTIVE         = 640,
  parameter int V_ACTIVE         = 480,
  parameter int LOGO_W           = 128,
  parameter int LOGO_H           = 64,
  parameter int STEP_X           = 1,
  parameter int STEP_Y           = 1,
  parameter int VSYNC_ACTIVE_LOW = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        vsync_i,
  input  logic        active_video_i,
  input  logic [9:0]  x_i,
  input  logic [8:0]  y_i,
  output logic [9:0]  lut_x_o,
  output logic [8:0]  lut_y_o,
  output logic        in_window_o,
  output logic [2:0]  color_o,
  output logic [9:0]  pos_x_o,
  output logic [8:0]  pos_y_o
`ifdef LOGO_BOUNCE_CORNER_CNT_EN
  ,
  output logic        corner_hit_o,
  output logic [15:0] corner_cnt_o
`endif
);

  // X arithmetic is carried out in 11 bits and Y in 10 bits, so sums and
  // differences never wrap.
  localparam logic [10:0] LP_X_MAX  = 11'(H_ACTIVE - LOGO_W);
  localparam logic [9:0]  LP_Y_MAX  = 10'(V_ACTIVE - LOGO_H);
  localparam logic [10:0] LP_STEP_X = 11'(STEP_X);
  localparam logic [9:0]  LP_STEP_Y = 10'(STEP_Y);
  localparam logic [10:0] LP_LOGO_W = 11'(LOGO_W);
  localparam logic [9:0]  LP_LOGO_H = 10'(LOGO_H);
  localparam logic [9:0]  LP_X_RST  = 10'((H_ACTIVE - LOGO_W) / 2);
  localparam logic [8:0]  LP_Y_RST  = 9'((V_ACTIVE - LOGO_H) / 2);
  localparam logic        LP_VS_IDLE = (VSYNC_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  typedef enum logic {
    DIR_FWD  = 1'b0,  // right for X, down for Y
    DIR_BACK = 1'b1   // left for X, up for Y
  } dir_e;

  generate
    if (LOGO_W >= H_ACTIVE || LOGO_H >= V_ACTIVE) begin : g_bad_geometry
      $fatal(1, "logo_bounce_engine: logo must be smaller than the active area");
    end
  endgenerate

  // ---------------------------------------------------------------- state
  logic       r_vsync_d;
  logic       r_armed;
  logic [9:0] r_pos_x;
  logic [8:0] r_pos_y;
  dir_e       r_dir_x;
  dir_e       r_dir_y;
  logic [2:0] r_color;
  logic       r_in_window;
  logic [9:0] r_lut_x;
  logic [8:0] r_lut_y;

  // ---------------------------------------------------------------- frame tick
  logic w_vs_now;
  logic w_vs_prev;
  logic w_tick;

  assign w_vs_now  = (vsync_i   != LP_VS_IDLE);
  assign w_vs_prev = (r_vsync_d != LP_VS_IDLE);
  // r_armed makes sure vsync has been seen deasserted at least once since
  // reset. Without it, a vsync that is already asserted when reset is
  // released would produce a tick.
  assign w_tick    = r_armed & w_vs_now & ~w_vs_prev;

  // ---------------------------------------------------------------- next position
  logic [10:0] w_x_sum;
  logic [10:0] w_x_diff;
  logic [9:0]  w_y_sum;
  logic [9:0]  w_y_diff;
  logic [9:0]  w_pos_x_nxt;
  logic [8:0]  w_pos_y_nxt;
  dir_e        w_dir_x_nxt;
  dir_e        w_dir_y_nxt;
  logic        w_hit_x;
  logic        w_hit_y;
  logic [2:0]  w_color_nxt;

  assign w_x_sum  = {1'b0, r_pos_x} + LP_STEP_X;
  assign w_x_diff = {1'b0, r_pos_x} - LP_STEP_X;
  assign w_y_sum  = {1'b0, r_pos_y} + LP_STEP_Y;
  assign w_y_diff = {1'b0, r_pos_y} - LP_STEP_Y;

  always_comb begin
    w_pos_x_nxt = r_pos_x;
    w_dir_x_nxt = r_dir_x;
    w_hit_x     = 1'b0;
    if (r_dir_x == DIR_FWD) begin
      if (w_x_sum >= LP_X_MAX) begin
        w_pos_x_nxt = LP_X_MAX[9:0];
        w_dir_x_nxt = DIR_BACK;
        w_hit_x     = 1'b1;
      end else begin
        w_pos_x_nxt = w_x_sum[9:0];
      end
    end else begin
      if ({1'b0, r_pos_x} <= LP_STEP_X) begin
        w_pos_x_nxt = '0;
        w_dir_x_nxt = DIR_FWD;
        w_hit_x     = 1'b1;
      end else begin
        w_pos_x_nxt = w_x_diff[9:0];
      end
    end
  end

  always_comb begin
    w_pos_y_nxt = r_pos_y;
    w_dir_y_nxt = r_dir_y;
    w_hit_y     = 1'b0;
    if (r_dir_y == DIR_FWD) begin
      if (w_y_sum >= LP_Y_MAX) begin
        w_pos_y_nxt = LP_Y_MAX[8:0];
        w_dir_y_nxt = DIR_BACK;
        w_hit_y     = 1'b1;
      end else begin
        w_pos_y_nxt = w_y_sum[8:0];
      end
    end else begin
      if ({1'b0, r_pos_y} <= LP_STEP_Y) begin
        w_pos_y_nxt = '0;
        w_dir_y_nxt = DIR_FWD;
        w_hit_y     = 1'b1;
      end else begin
        w_pos_y_nxt = w_y_diff[8:0];
      end
    end
  end

  // The colour steps through 001..111 and skips 000, so the logo is never
  // blanked.
  assign w_color_nxt = (r_color == 3'b111) ? 3'b001 : r_color + 3'd1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_vsync_d <= LP_VS_IDLE;
      r_armed   <= 1'b0;
      r_pos_x   <= LP_X_RST;
      r_pos_y   <= LP_Y_RST;
      r_dir_x   <= DIR_FWD;
      r_dir_y   <= DIR_FWD;
      r_color   <= 3'b111;
    end else begin
      r_vsync_d <= vsync_i;
      if (!w_vs_now) begin
        r_armed <= 1'b1;
      end
      if (w_tick) begin
        r_pos_x <= w_pos_x_nxt;
        r_pos_y <= w_pos_y_nxt;
        r_dir_x <= w_dir_x_nxt;
        r_dir_y <= w_dir_y_nxt;
        // A corner hit sets both flags but still advances only one step.
        if (w_hit_x || w_hit_y) begin
          r_color <= w_color_nxt;
        end
      end
    end
  end

  // ---------------------------------------------------------------- window path
  logic [10:0] w_x_end;
  logic [9:0]  w_y_end;
  logic        w_in_window;
  logic [9:0]  w_rel_x;
  logic [8:0]  w_rel_y;

  assign w_x_end     = {1'b0, r_pos_x} + LP_LOGO_W;
  assign w_y_end     = {1'b0, r_pos_y} + LP_LOGO_H;
  assign w_in_window = active_video_i
                     & (x_i >= r_pos_x) & ({1'b0, x_i} < w_x_end)
                     & (y_i >= r_pos_y) & ({1'b0, y_i} < w_y_end);
  assign w_rel_x     = x_i - r_pos_x;
  assign w_rel_y     = y_i - r_pos_y;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_in_window <= 1'b0;
      r_lut_x     <= '0;
      r_lut_y     <= '0;
    end else begin
      r_in_window <= w_in_window;
      r_lut_x     <= w_in_window ? w_rel_x : '0;
      r_lut_y     <= w_in_window ? w_rel_y : '0;
    end
  end

`ifdef LOGO_BOUNCE_CORNER_CNT_EN
  // ---------------------------------------------------------------- corner stats
  logic        r_corner_hit;
  logic [15:0] r_corner_cnt;
  logic        w_corner;

  assign w_corner = w_tick & w_hit_x & w_hit_y;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_corner_hit <= 1'b0;
      r_corner_cnt <= '0;
    end else begin
      r_corner_hit <= w_corner;
      if (w_corner && (r_corner_cnt != 16'hFFFF)) begin
        r_corner_cnt <= r_corner_cnt + 16'd1;
      end
    end
  end

  assign corner_hit_o = r_corner_hit;
  assign corner_cnt_o = r_corner_cnt;
`endif

  assign pos_x_o     = r_pos_x;
  assign pos_y_o     = r_pos_y;
  assign color_o     = r_color;
  assign in_window_o = r_in_window;
  assign lut_x_o     = r_lut_x;
  assign lut_y_o     = r_lut_y;

endmodule

// File: tb/tb_logo_bounce_engine.sv
// Bench for logo_bounce_engine. It uses two instances:
//   dut_a  default geometry, step 1
//   dut_b  544x480 area with step 16, so that X and Y are the same distance
//          from their far edges and reach them on the same tick (a corner)
// The reference model finds each position as a triangle wave of the tick
// count. The colour is a function of the number of ticks that reached an edge.

module tb_logo_bounce_engine;

  // ------------------------------------------------------------ clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       vsync;
  logic       av;
  logic [9:0] x;
  logic [8:0] y;

  logic [9:0] a_lut_x, b_lut_x, a_pos_x, b_pos_x;
  logic [8:0] a_lut_y, b_lut_y, a_pos_y, b_pos_y;
  logic       a_win, b_win;
  logic [2:0] a_col, b_col;
`ifdef LOGO_BOUNCE_CORNER_CNT_EN
  logic        a_chit, b_chit;
  logic [15:0] a_ccnt, b_ccnt;
`endif

  logo_bounce_engine dut_a (
    .clk_i(clk), .rst_ni(rst_n), .vsync_i(vsync), .active_video_i(av),
    .x_i(x), .y_i(y), .lut_x_o(a_lut_x), .lut_y_o(a_lut_y),
    .in_window_o(a_win), .color_o(a_col), .pos_x_o(a_pos_x), .pos_y_o(a_pos_y)
`ifdef LOGO_BOUNCE_CORNER_CNT_EN
    , .corner_hit_o(a_chit), .corner_cnt_o(a_ccnt)
`endif
  );

  logo_bounce_engine #(.H_ACTIVE(544), .STEP_X(16), .STEP_Y(16)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .vsync_i(vsync), .active_video_i(av),
    .x_i(x), .y_i(y), .lut_x_o(b_lut_x), .lut_y_o(b_lut_y),
    .in_window_o(b_win), .color_o(b_col), .pos_x_o(b_pos_x), .pos_y_o(b_pos_y)
`ifdef LOGO_BOUNCE_CORNER_CNT_EN
    , .corner_hit_o(b_chit), .corner_cnt_o(b_ccnt)
`endif
  );

  // ------------------------------------------------------------ scoreboard
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------ reference model
  // Unfold the bounce onto a line: the position is a triangle wave with
  // period 2*m.
  function automatic int tri_pos(input int start, input int n, input int step, input int m);
    int p;
    p = (start + n * step) % (2 * m);
    return (p <= m) ? p : 2 * m - p;
  endfunction

  function automatic bit on_edge(input int start, input int n, input int step, input int m);
    return ((start + n * step) % m) == 0;
  endfunction

  function automatic int col_of(input int h);
    return (h == 0) ? 7 : ((h - 1) % 7) + 1;
  endfunction

  int m_n, m_hits_a, m_hits_b, m_ccnt_a, m_ccnt_b;
  bit m_armed, m_prev_as, m_corner_a, m_corner_b;
  int m_win_a, m_lx_a, m_ly_a, m_win_b, m_lx_b, m_ly_b;

  always @(posedge clk or negedge rst_n) begin
    int pax, pay, pbx, pby;
    bit now_as, tick, ex, ey;
    if (!rst_n) begin
      m_n = 0; m_hits_a = 0; m_hits_b = 0; m_ccnt_a = 0; m_ccnt_b = 0;
      m_armed = 0; m_prev_as = 0; m_corner_a = 0; m_corner_b = 0;
      m_win_a = 0; m_lx_a = 0; m_ly_a = 0; m_win_b = 0; m_lx_b = 0; m_ly_b = 0;
    end else begin
      pax = tri_pos(256, m_n, 1, 512);
      pay = tri_pos(208, m_n, 1, 416);
      pbx = tri_pos(208, m_n, 16, 416);
      pby = tri_pos(208, m_n, 16, 416);
      m_win_a = (av && int'(x) >= pax && int'(x) < pax + 128 && int'(y) >= pay && int'(y) < pay + 64) ? 1 : 0;
      m_lx_a  = m_win_a ? int'(x) - pax : 0;
      m_ly_a  = m_win_a ? int'(y) - pay : 0;
      m_win_b = (av && int'(x) >= pbx && int'(x) < pbx + 128 && int'(y) >= pby && int'(y) < pby + 64) ? 1 : 0;
      m_lx_b  = m_win_b ? int'(x) - pbx : 0;
      m_ly_b  = m_win_b ? int'(y) - pby : 0;
      now_as    = (vsync == 1'b0);
      tick      = m_armed && now_as && !m_prev_as;
      m_prev_as = now_as;
      if (!now_as) m_armed = 1;
      m_corner_a = 0;
      m_corner_b = 0;
      if (tick) begin
        m_n++;
        ex = on_edge(256, m_n, 1, 512);
        ey = on_edge(208, m_n, 1, 416);
        if (ex || ey) m_hits_a++;
        if (ex && ey) begin m_corner_a = 1; if (m_ccnt_a < 65535) m_ccnt_a++; end
        ex = on_edge(208, m_n, 16, 416);
        ey = on_edge(208, m_n, 16, 416);
        if (ex || ey) m_hits_b++;
        if (ex && ey) begin m_corner_b = 1; if (m_ccnt_b < 65535) m_ccnt_b++; end
      end
    end
  end

  // ------------------------------------------------------------ compare process
  always @(negedge clk) begin
    chk("a_pos_x", a_pos_x, tri_pos(256, m_n, 1, 512));
    chk("a_pos_y", a_pos_y, tri_pos(208, m_n, 1, 416));
    chk("a_color", a_col, col_of(m_hits_a));
    chk("a_in_window", a_win, m_win_a);
    chk("a_lut_x", a_lut_x, m_lx_a);
    chk("a_lut_y", a_lut_y, m_ly_a);
    chk("b_pos_x", b_pos_x, tri_pos(208, m_n, 16, 416));
    chk("b_pos_y", b_pos_y, tri_pos(208, m_n, 16, 416));
    chk("b_color", b_col, col_of(m_hits_b));
    chk("b_in_window", b_win, m_win_b);
    chk("b_lut_x", b_lut_x, m_lx_b);
    chk("b_lut_y", b_lut_y, m_ly_b);
`ifdef LOGO_BOUNCE_CORNER_CNT_EN
    chk("a_corner_hit", a_chit, m_corner_a);
    chk("a_corner_cnt", a_ccnt, m_ccnt_a);
    chk("b_corner_hit", b_chit, m_corner_b);
    chk("b_corner_cnt", b_ccnt, m_ccnt_b);
`endif
  end

  // ------------------------------------------------------------ driver tasks
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pix(input logic a, input int px, input int py);
    av = a;
    x  = 10'(px);
    y  = 9'(py);
  endtask

  // The tick fires on the first clock edge that samples vsync asserted (low).
  task automatic tick_pulse();
    vsync = 1'b1;
    cyc(3);
    vsync = 1'b0;
    cyc(3);
  endtask

  // ------------------------------------------------------------ directed test
  initial begin
    rst_n = 1'b0;
    vsync = 1'b0;
    pix(1'b0, 0, 0);
    cyc(3);
    rst_n = 1'b1;
    // vsync is held asserted across reset release, so no tick may fire.
    cyc(5);
    chk("lit_reset_pos_x", a_pos_x, 256);
    chk("lit_reset_pos_y", a_pos_y, 208);
    chk("lit_reset_color", a_col, 7);
    chk("lit_reset_win", a_win, 0);
    chk("lit_reset_lut_x", a_lut_x, 0);

    // Blanking: the counters run while video is inactive.
    for (int i = 0; i < 20; i++) begin
      pix(1'b0, 250 + i * 7, 200 + i);
      cyc(1);
    end
    chk("lit_blank_win", a_win, 0);

    // Window edges at pos 256/208.
    pix(1'b1, 256, 208); cyc(1);
    chk("lit_win_origin", a_win, 1);
    chk("lit_lut_x_origin", a_lut_x, 0);
    chk("lit_lut_y_origin", a_lut_y, 0);
    pix(1'b1, 383, 271); cyc(1);
    chk("lit_lut_x_last", a_lut_x, 127);
    chk("lit_lut_y_last", a_lut_y, 63);
    pix(1'b1, 384, 230); cyc(1);
    chk("lit_win_x_past", a_win, 0);
    chk("lit_lut_x_past", a_lut_x, 0);
    pix(1'b1, 255, 230); cyc(1);
    chk("lit_win_x_before", a_win, 0);
    pix(1'b1, 300, 272); cyc(1);
    chk("lit_win_y_past", a_win, 0);
    pix(1'b0, 300, 230); cyc(1);
    chk("lit_win_av_low", a_win, 0);

    // Sweep across the top and bottom edges of the window.
    for (int yy = 204; yy < 276; yy += 4) begin
      for (int xx = 250; xx < 392; xx += 3) begin
        pix(1'b1, xx, yy + (xx % 4));
        cyc(1);
      end
    end
    pix(1'b0, 0, 0);

    // Deassert vsync, then hold it asserted for two lines: exactly one tick.
    vsync = 1'b1;
    cyc(3);
    vsync = 1'b0;
    cyc(1600);
    chk("lit_hold_pos_x", a_pos_x, 257);
    chk("lit_hold_pos_y", a_pos_y, 209);
    tick_pulse();
    tick_pulse();
    chk("lit_two_pulses_x", a_pos_x, 259);
    chk("lit_two_pulses_y", a_pos_y, 211);

    // Ticks 4..12, then tick 13 is the corner of dut_b.
    for (int t = 4; t <= 12; t++) tick_pulse();
    chk("lit_b_pre_corner_x", b_pos_x, 400);
    vsync = 1'b1;
    cyc(3);
    vsync = 1'b0;
    cyc(1);
    chk("lit_b_corner_x", b_pos_x, 416);
    chk("lit_b_corner_y", b_pos_y, 416);
    chk("lit_b_corner_color", b_col, 1);
`ifdef LOGO_BOUNCE_CORNER_CNT_EN
    chk("lit_b_corner_hit", b_chit, 1);
    chk("lit_b_corner_cnt", b_ccnt, 1);
    cyc(1);
    chk("lit_b_corner_hit_end", b_chit, 0);
    cyc(1);
`else
    cyc(2);
`endif

    // Run to tick 208: Y reaches the bottom edge.
    for (int t = 14; t <= 208; t++) tick_pulse();
    chk("lit_t208_pos_y", a_pos_y, 416);
    chk("lit_t208_pos_x", a_pos_x, 464);
    chk("lit_t208_color", a_col, 1);
    // Run to tick 256: X reaches the right edge.
    for (int t = 209; t <= 256; t++) tick_pulse();
    chk("lit_t256_pos_x", a_pos_x, 512);
    chk("lit_t256_pos_y", a_pos_y, 368);
    chk("lit_t256_color", a_col, 2);
    tick_pulse();
    chk("lit_t257_pos_x", a_pos_x, 511);
    chk("lit_t257_pos_y", a_pos_y, 367);

    // Reset asserted between clock edges during active video.
    pix(1'b1, 520, 380);
    cyc(1);
    chk("lit_pre_rst_win", a_win, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("lit_async_pos_x", a_pos_x, 256);
    chk("lit_async_pos_y", a_pos_y, 208);
    chk("lit_async_color", a_col, 7);
    chk("lit_async_win", a_win, 0);
    chk("lit_async_lut_x", a_lut_x, 0);
    chk("lit_async_lut_y", a_lut_y, 0);
    cyc(2);
    rst_n = 1'b1;
    pix(1'b0, 0, 0);
    cyc(3);
    chk("lit_rearm_none", a_pos_x, 256);
    tick_pulse();
    chk("lit_restart_x", a_pos_x, 257);
    chk("lit_restart_y", a_pos_y, 209);
    cyc(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
